// File: rtl/down_counter8_if.sv
// down_counter8_if: control and status bundle for down_counter8.
// master drives load/load_val/start/stop/auto_reload and observes qout/busy/held/tc;
// slave is the counter side.
interface down_counter8_if #(
    parameter int WIDTH = 8
);
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             stop;
    logic             auto_reload;
    logic [WIDTH-1:0] qout;
    logic             busy;
    logic             held;
    logic             tc;
    modport master (
        output load, load_val, start, stop, auto_reload,
        input  qout, busy, held, tc
    );
    modport slave (
        input  load, load_val, start, stop, auto_reload,
        output qout, busy, held, tc
    );
endinterface

// File: rtl/down_counter8.sv
// down_counter8: loadable down-counter/timer with prescaler, one-shot and auto-reload modes.
// Ports: clk (rising edge), reset_n (async, active-low), bus (down_counter8_if.slave):
//   load/load_val capture count and reload value, start/stop control the run,
//   auto_reload selects periodic mode, qout is the count, busy/held expose RUN/HOLD,
//   tc is a one-cycle terminal-count pulse.
module down_counter8 #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 1
) (
    input logic            clk,
    input logic            reset_n,
    down_counter8_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
    state_t           state, state_n;
    logic [WIDTH-1:0] q, q_n, rl, rl_n;
    logic [7:0]       pc, pc_n;
    logic             tc, tc_n, tick;
    assign tick = pc == 8'(PRESCALE - 1);
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state <= IDLE;
            q     <= '0;
            rl    <= '0;
            pc    <= '0;
            tc    <= 1'b0;
        end else begin
            state <= state_n;
            q     <= q_n;
            rl    <= rl_n;
            pc    <= pc_n;
            tc    <= tc_n;
        end
    always_comb begin
        state_n = state;
        q_n     = q;
        rl_n    = rl;
        pc_n    = pc;
        tc_n    = 1'b0;
        if (bus.load) begin
            q_n     = bus.load_val;
            rl_n    = bus.load_val;
            pc_n    = '0;
            state_n = IDLE;
        end else begin
            case (state)
                IDLE:
                    if (bus.start && !bus.stop && q != '0) begin
                        state_n = RUN;
                        pc_n    = '0;
                    end
                RUN:
                    if (bus.stop)
                        state_n = HOLD;
                    else begin
                        pc_n = tick ? '0 : pc + 8'd1;
                        if (tick) begin
                            if (q > WIDTH'(1))
                                q_n = q - WIDTH'(1);
                            else begin
                                // terminal tick: reload only when there is a nonzero value to reload
                                tc_n = 1'b1;
                                if (bus.auto_reload && rl != '0)
                                    q_n = rl;
                                else begin
                                    q_n     = '0;
                                    state_n = IDLE;
                                end
                            end
                        end
                    end
                HOLD:
                    if (bus.start && !bus.stop)
                        state_n = RUN;
                default:
                    state_n = IDLE;
            endcase
        end
    end
    assign bus.qout = q;
    assign bus.busy = state == RUN;
    assign bus.held = state == HOLD;
    assign bus.tc   = tc;
endmodule

// File: tb/tb_down_counter8.sv
// tb_down_counter8: directed and randomized checks of down_counter8 (PRESCALE 1 and 4) against a reference model.
module tb_down_counter8;
    logic clk = 1'b0;
    logic reset_n;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_tc;
    bit   ld, st, sp, ar;
    int   lv;
    int   mq[2], mrl[2], mph[2];
    bit   mrun[2], mhold[2], mtc[2];

    always #5 clk = ~clk;

    down_counter8_if #(.WIDTH(8)) b1 ();
    down_counter8_if #(.WIDTH(8)) b4 ();

    down_counter8 #(.WIDTH(8), .PRESCALE(1)) u1 (.clk(clk), .reset_n(reset_n), .bus(b1));
    down_counter8 #(.WIDTH(8), .PRESCALE(4)) u4 (.clk(clk), .reset_n(reset_n), .bus(b4));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit l, input int v, input bit s, input bit t, input bit a);
        ld = l; lv = v & 255; st = s; sp = t; ar = a;
        b1.load = l; b1.load_val = 8'(lv); b1.start = s; b1.stop = t; b1.auto_reload = a;
        b4.load = l; b4.load_val = 8'(lv); b4.start = s; b4.stop = t; b4.auto_reload = a;
    endtask

    task automatic m_reset();
        for (int k = 0; k < 2; k++) begin
            mq[k] = 0; mrl[k] = 0; mph[k] = 0;
            mrun[k] = 0; mhold[k] = 0; mtc[k] = 0;
        end
    endtask

    // Reference behaviour: one clock edge applied to counter k with prescale p
    task automatic m_step(input int k, input int p);
        mtc[k] = 0;
        if (ld) begin
            mq[k] = lv; mrl[k] = lv; mph[k] = 0; mrun[k] = 0; mhold[k] = 0;
        end else if (mrun[k]) begin
            if (sp) begin
                mrun[k] = 0; mhold[k] = 1;
            end else begin
                mph[k]++;
                if (mph[k] == p) begin
                    mph[k] = 0;
                    if (mq[k] > 1) mq[k]--;
                    else if (ar && mrl[k] != 0) begin
                        mq[k] = mrl[k]; mtc[k] = 1;
                    end else begin
                        mq[k] = 0; mtc[k] = 1; mrun[k] = 0;
                    end
                end
            end
        end else if (mhold[k]) begin
            if (st && !sp) begin
                mhold[k] = 0; mrun[k] = 1;
            end
        end else if (st && !sp && mq[k] != 0) begin
            mrun[k] = 1; mph[k] = 0;
        end
    endtask

    task automatic compare_all();
        chk("p1_qout", b1.qout, mq[0]);
        chk("p1_busy", b1.busy, mrun[0]);
        chk("p1_held", b1.held, mhold[0]);
        chk("p1_tc",   b1.tc,   mtc[0]);
        chk("p4_qout", b4.qout, mq[1]);
        chk("p4_busy", b4.busy, mrun[1]);
        chk("p4_held", b4.held, mhold[1]);
        chk("p4_tc",   b4.tc,   mtc[1]);
    endtask

    task automatic step();
        @(posedge clk);
        m_step(0, 1);
        m_step(1, 4);
        #1;
        compare_all();
    endtask

    initial begin
        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        m_reset();
        #3;
        compare_all();
        chk("rst_qout", b1.qout, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step();

        // one-shot, PRESCALE 1
        drive(1, 5, 0, 0, 0); step();
        drive(0, 0, 1, 0, 0); step();
        chk("os_start_busy", b1.busy, 1);
        chk("os_start_q", b1.qout, 5);
        drive(0, 0, 0, 0, 0);
        for (int i = 4; i >= 0; i--) begin
            step();
            chk("os_q", b1.qout, i);
            chk("os_tc", b1.tc, i == 0);
            chk("os_busy", b1.busy, i != 0);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            chk("os_after_q", b1.qout, 0);
            chk("os_after_tc", b1.tc, 0);
        end

        // periodic
        drive(1, 3, 0, 0, 1); step();
        drive(0, 0, 1, 0, 1); step();
        drive(0, 0, 0, 0, 1);
        n_tc = 0;
        for (int i = 1; i <= 12; i++) begin
            step();
            chk("per_q", b1.qout, 3 - (i % 3));
            chk("per_tc", b1.tc, (i % 3) == 0);
            n_tc += int'(b1.tc);
        end
        chk("per_tc_count", n_tc, 4);

        // prescale 4
        drive(1, 2, 0, 0, 0); step();
        drive(0, 0, 1, 0, 0); step();
        drive(0, 0, 0, 0, 0);
        for (int i = 1; i <= 8; i++) begin
            step();
            chk("ps_q", b4.qout, i < 4 ? 2 : (i < 8 ? 1 : 0));
            chk("ps_tc", b4.tc, i == 8);
        end

        // hold / resume
        drive(1, 10, 0, 0, 0); step();
        drive(0, 0, 1, 0, 0); step();
        drive(0, 0, 0, 0, 0); step(); step(); step();
        chk("hold_pre_q", b1.qout, 7);
        drive(0, 0, 0, 1, 0); step();
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("hold_q", b1.qout, 7);
            chk("hold_held", b1.held, 1);
        end
        drive(0, 0, 1, 0, 0); step();
        chk("resume_busy", b1.busy, 1);
        chk("resume_q", b1.qout, 7);
        drive(0, 0, 0, 0, 0);
        n_tc = 0;
        for (int i = 6; i >= 0; i--) begin
            step();
            chk("resume_q", b1.qout, i);
            n_tc += int'(b1.tc);
        end
        chk("resume_tc_count", n_tc, 1);

        // start with qout == 0 ignored
        drive(0, 0, 1, 0, 0); step();
        chk("zero_start_busy", b1.busy, 0);
        chk("zero_start_tc", b1.tc, 0);
        step();
        chk("zero_start_tc2", b1.tc, 0);

        // load on the terminal tick edge
        drive(1, 2, 0, 0, 0); step();
        drive(0, 0, 1, 0, 0); step();
        drive(0, 0, 0, 0, 0); step();
        chk("ldtc_pre_q", b1.qout, 1);
        drive(1, 9, 0, 0, 0); step();
        chk("ldtc_q", b1.qout, 9);
        chk("ldtc_tc", b1.tc, 0);
        chk("ldtc_busy", b1.busy, 0);
        drive(0, 0, 0, 0, 0); step();
        chk("ldtc_tc2", b1.tc, 0);

        // start and stop together
        drive(0, 0, 1, 0, 0); step();
        drive(0, 0, 1, 1, 0); step();
        chk("ss_run_held", b1.held, 1);
        step();
        chk("ss_hold_held", b1.held, 1);
        chk("ss_hold_q", b1.qout, 9);
        drive(1, 4, 0, 0, 0); step();
        drive(0, 0, 1, 1, 0); step();
        chk("ss_idle_busy", b1.busy, 0);
        chk("ss_idle_held", b1.held, 0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 15) == 0,
                  $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 5)),
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 1) == 1);
            step();
        end

        // asynchronous reset mid-count
        drive(1, 8'h38, 0, 0, 0); step();
        drive(0, 0, 1, 0, 0); step();
        drive(0, 0, 0, 0, 0); step();
        chk("arst_pre_q", b1.qout, 8'h37);
        #2;
        reset_n = 1'b0;
        m_reset();
        #1;
        chk("arst_q", b1.qout, 0);
        chk("arst_busy", b1.busy, 0);
        chk("arst_tc", b1.tc, 0);
        compare_all();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
